// File: rtl/seg_pkg.sv
// Shared 7-segment display definitions: display codes, sequencer state
// encoding and the helper that picks one character out of a packed message.
package seg_pkg;

   localparam logic [3:0] D0      = 4'd0;
   localparam logic [3:0] D1      = 4'd1;
   localparam logic [3:0] D2      = 4'd2;
   localparam logic [3:0] D3      = 4'd3;
   localparam logic [3:0] D4      = 4'd4;
   localparam logic [3:0] D5      = 4'd5;
   localparam logic [3:0] D6      = 4'd6;
   localparam logic [3:0] D7      = 4'd7;
   localparam logic [3:0] D8      = 4'd8;
   localparam logic [3:0] D9      = 4'd9;
   localparam logic [3:0] D_BLANK = 4'd10;
   localparam logic [3:0] D_V     = 4'd11;
   localparam logic [3:0] D_E     = 4'd12;
   localparam logic [3:0] D_R     = 4'd13;
   localparam logic [3:0] D_DASH  = 4'd14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      CHAR  = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // Messages are packed char0 in the top nibble down to char3 in the bottom.
   function automatic logic [3:0] msg_char(input logic [15:0] chars, input logic [1:0] idx);
      logic [3:0] c_s;
      case (idx)
         2'd0:    c_s = chars[15:12];
         2'd1:    c_s = chars[11:8];
         2'd2:    c_s = chars[7:4];
         default: c_s = chars[3:0];
      endcase
      return c_s;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that parks at zero; zero flags the end of a dwell.
module dwell_timer #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_r;

   // Load has priority; otherwise count down and hold once zero is reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/seg_msg_sequencer.sv
// Arbitrates score/status messages onto the single 7-segment digit and plays
// the granted message as repeated frames of blank, char0..char3.
module seg_msg_sequencer
   import seg_pkg::*;
#(
   parameter int DWELL_CYCLES = 10_000_000,
   parameter int CNT_W        = 24,
   parameter int REPEATS      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_score,
   input  logic [15:0] score_chars,
   input  logic        req_status,
   input  logic [15:0] status_chars,
   input  logic        abort,
   output logic        ack_score,
   output logic        ack_status,
   output logic        busy,
   output logic        grant_id,
   output logic        msg_done,
   output logic [3:0]  disp_code
);

   localparam int               FC_W       = (REPEATS > 1) ? $clog2(REPEATS) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [FC_W-1:0]  FC_LAST    = (REPEATS == 0) ? {FC_W{1'b0}} : FC_W'(REPEATS - 1);
   localparam logic [FC_W-1:0]  FC_MAX     = {FC_W{1'b1}};

   seq_state_t  state_r, state_s;
   logic [1:0]  ci_r, ci_s;
   logic [FC_W-1:0] fc_r, fc_s;
   logic [15:0] chars_r, chars_s;
   logic        last_r, last_s;          // source granted last; the other one wins a tie
   logic        grant_id_r, grant_id_s;
   logic        ack_score_r, ack_score_s;
   logic        ack_status_r, ack_status_s;
   logic        busy_r, busy_s;
   logic        msg_done_r, msg_done_s;
   logic [3:0]  disp_r, disp_s;
   logic        pick_s;
   logic        load_s;
   logic        dwell_zero_s;

   dwell_timer #(.CNT_W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .load_val (DWELL_LAST),
      .zero     (dwell_zero_s)
   );

   // Next-state, arbitration and next-output decode.
   always_comb begin
      state_s      = state_r;
      ci_s         = ci_r;
      fc_s         = fc_r;
      chars_s      = chars_r;
      last_s       = last_r;
      grant_id_s   = grant_id_r;
      ack_score_s  = 1'b0;
      ack_status_s = 1'b0;
      load_s       = 1'b0;
      pick_s       = 1'b0;

      case (state_r)
         IDLE: begin
            if (!abort && (req_score || req_status)) begin
               pick_s       = (req_score && req_status) ? ~last_r : req_status;
               grant_id_s   = pick_s;
               chars_s      = pick_s ? status_chars : score_chars;
               ack_score_s  = ~pick_s;
               ack_status_s = pick_s;
               ci_s         = 2'd0;
               fc_s         = {FC_W{1'b0}};
               load_s       = 1'b1;
               state_s      = BLANK;
            end else begin
               state_s = IDLE;
            end
         end
         BLANK: begin
            if (abort) begin
               last_s  = grant_id_r;
               state_s = IDLE;
            end else if (dwell_zero_s) begin
               load_s  = 1'b1;
               ci_s    = 2'd0;
               state_s = CHAR;
            end else begin
               state_s = BLANK;
            end
         end
         CHAR: begin
            if (abort) begin
               last_s  = grant_id_r;
               state_s = IDLE;
            end else if (dwell_zero_s && (ci_r != 2'd3)) begin
               ci_s   = ci_r + 2'd1;
               load_s = 1'b1;
            end else if (dwell_zero_s && (REPEATS != 0) && (fc_r == FC_LAST)) begin
               state_s = DONE;
            end else if (dwell_zero_s) begin
               fc_s    = (fc_r != FC_MAX) ? (fc_r + {{(FC_W-1){1'b0}}, 1'b1}) : fc_r;
               load_s  = 1'b1;
               state_s = BLANK;
            end else begin
               state_s = CHAR;
            end
         end
         DONE: begin
            last_s  = grant_id_r;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      case (state_s)
         BLANK:   disp_s = D_BLANK;
         CHAR:    disp_s = msg_char(chars_s, ci_s);
         default: disp_s = D_DASH;
      endcase
      busy_s     = (state_s == BLANK) || (state_s == CHAR);
      msg_done_s = (state_s == DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         ci_r         <= 2'd0;
         fc_r         <= {FC_W{1'b0}};
         chars_r      <= 16'd0;
         last_r       <= 1'b1;
         grant_id_r   <= 1'b0;
         ack_score_r  <= 1'b0;
         ack_status_r <= 1'b0;
         busy_r       <= 1'b0;
         msg_done_r   <= 1'b0;
         disp_r       <= D_DASH;
      end else begin
         state_r      <= state_s;
         ci_r         <= ci_s;
         fc_r         <= fc_s;
         chars_r      <= chars_s;
         last_r       <= last_s;
         grant_id_r   <= grant_id_s;
         ack_score_r  <= ack_score_s;
         ack_status_r <= ack_status_s;
         busy_r       <= busy_s;
         msg_done_r   <= msg_done_s;
         disp_r       <= disp_s;
      end
   end

   assign ack_score  = ack_score_r;
   assign ack_status = ack_status_r;
   assign busy       = busy_r;
   assign grant_id   = grant_id_r;
   assign msg_done   = msg_done_r;
   assign disp_code  = disp_r;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Scoreboard bench for seg_msg_sequencer: three instances with REPEATS 1, 2
// and 0, short dwell, expected per-cycle outputs queued at stimulus time.
module tb_seg_msg_sequencer;
   import seg_pkg::*;

   localparam int DW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_score    [3];
   logic        req_status   [3];
   logic        abort        [3];
   logic [15:0] score_chars  [3];
   logic [15:0] status_chars [3];
   logic        ack_score    [3];
   logic        ack_status   [3];
   logic        busy         [3];
   logic        grant_id     [3];
   logic        msg_done     [3];
   logic [3:0]  disp_code    [3];

   int checks = 0;
   int errors = 0;
   logic [8:0] sb[$];

   always #5 clk = ~clk;

   seg_msg_sequencer #(.DWELL_CYCLES(DW), .CNT_W(4), .REPEATS(1)) u_dut_r1 (
      .clk(clk), .rst(rst), .req_score(req_score[0]), .score_chars(score_chars[0]),
      .req_status(req_status[0]), .status_chars(status_chars[0]), .abort(abort[0]),
      .ack_score(ack_score[0]), .ack_status(ack_status[0]), .busy(busy[0]),
      .grant_id(grant_id[0]), .msg_done(msg_done[0]), .disp_code(disp_code[0]));

   seg_msg_sequencer #(.DWELL_CYCLES(DW), .CNT_W(4), .REPEATS(2)) u_dut_r2 (
      .clk(clk), .rst(rst), .req_score(req_score[1]), .score_chars(score_chars[1]),
      .req_status(req_status[1]), .status_chars(status_chars[1]), .abort(abort[1]),
      .ack_score(ack_score[1]), .ack_status(ack_status[1]), .busy(busy[1]),
      .grant_id(grant_id[1]), .msg_done(msg_done[1]), .disp_code(disp_code[1]));

   seg_msg_sequencer #(.DWELL_CYCLES(DW), .CNT_W(4), .REPEATS(0)) u_dut_r0 (
      .clk(clk), .rst(rst), .req_score(req_score[2]), .score_chars(score_chars[2]),
      .req_status(req_status[2]), .status_chars(status_chars[2]), .abort(abort[2]),
      .ack_score(ack_score[2]), .ack_status(ack_status[2]), .busy(busy[2]),
      .grant_id(grant_id[2]), .msg_done(msg_done[2]), .disp_code(disp_code[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         errors = errors;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observation word: {grant_id, ack_score, ack_status, msg_done, busy, disp_code}
   function automatic logic [8:0] obs(input int s);
      return {grant_id[s], ack_score[s], ack_status[s], msg_done[s], busy[s], disp_code[s]};
   endfunction

   function automatic logic [8:0] idle_ent(input logic gid);
      return {gid, 1'b0, 1'b0, 1'b0, 1'b0, D_DASH};
   endfunction

   // Queue the expected per-cycle outputs from the ack cycle onwards.
   task automatic push_msg(input logic src, input logic [15:0] chars, input int frames, input bit with_done);
      logic [3:0] c;
      bit first;
      for (int f = 0; f < frames; f++) begin
         for (int slot = 0; slot < 5; slot++) begin
            for (int k = 0; k < DW; k++) begin
               first = (f == 0) && (slot == 0) && (k == 0);
               if (slot == 0) c = D_BLANK;
               else c = 4'(chars >> (4 * (4 - slot)));
               sb.push_back({src, first && !src, first && src, 1'b0, 1'b1, c});
            end
         end
      end
      if (with_done) begin
         sb.push_back({src, 1'b0, 1'b0, 1'b1, 1'b0, D_DASH});
         sb.push_back(idle_ent(src));
      end
   endtask

   // Compare one queued entry per cycle; release a request once it is acked.
   task automatic drain(input int s, input int poke_at);
      int n = 0;
      logic [8:0] e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("inst%0d_cyc%0d", s, n + 1), 32'(obs(s)), 32'(e));
         if (e[7]) req_score[s] = 1'b0;
         if (e[6]) req_status[s] = 1'b0;
         if (n == poke_at) score_chars[s] = 16'h9999;
         n++;
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_score[i] = 1'b0; req_status[i] = 1'b0; abort[i] = 1'b0;
         score_chars[i] = 16'h0000; status_chars[i] = 16'h0000;
      end
      #3;
      for (int i = 0; i < 3; i++) chk($sformatf("reset_inst%0d", i), 32'(obs(i)), 32'(idle_ent(1'b0)));
      #9 rst = 1'b0;
      step();
      sb.push_back(idle_ent(1'b0)); sb.push_back(idle_ent(1'b0));
      drain(0, -1);

      // Single score message; inputs change mid-frame but latched chars play.
      score_chars[0] = 16'h1234; req_score[0] = 1'b1;
      step();
      push_msg(1'b0, 16'h1234, 1, 1'b1);
      drain(0, 6);

      // Asynchronous reset mid-frame.
      score_chars[0] = 16'h4321; req_score[0] = 1'b1;
      step();
      req_score[0] = 1'b0;
      repeat (8) step();
      chk("busy_before_rst", 32'(busy[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("disp_async_rst", 32'(disp_code[0]), 32'(D_DASH));
      chk("busy_async_rst", 32'(busy[0]), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) sb.push_back(idle_ent(1'b0));
      drain(0, -1);

      // Simultaneous requests after reset: score first, then status.
      score_chars[0] = 16'h5678; status_chars[0] = 16'hB0BE;
      req_score[0] = 1'b1; req_status[0] = 1'b1;
      step();
      push_msg(1'b0, 16'h5678, 1, 1'b1);
      push_msg(1'b1, 16'hB0BE, 1, 1'b1);
      drain(0, -1);

      // Abort in IDLE beats a same-cycle request.
      req_status[0] = 1'b1; abort[0] = 1'b1;
      step();
      chk("abort_blocks_ack", 32'(ack_status[0]), 32'd0);
      chk("abort_blocks_busy", 32'(busy[0]), 32'd0);
      abort[0] = 1'b0;
      step();
      push_msg(1'b1, 16'hB0BE, 1, 1'b1);
      drain(0, -1);

      // Mid-message abort: no msg_done, pointer moves past the aborted source.
      score_chars[0] = 16'h1111; status_chars[0] = 16'h2222;
      req_score[0] = 1'b1; req_status[0] = 1'b1;
      step();
      chk("rr_score_first", 32'({ack_score[0], grant_id[0]}), 32'b10);
      repeat (6) step();
      abort[0] = 1'b1;
      step();
      abort[0] = 1'b0;
      chk("abort_mid_idle", 32'(obs(0)), 32'(idle_ent(1'b0)));
      step();
      chk("rr_after_abort", 32'({ack_status[0], ack_score[0], grant_id[0]}), 32'b101);
      req_score[0] = 1'b0; req_status[0] = 1'b0; abort[0] = 1'b1;
      step();
      abort[0] = 1'b0;
      chk("abort2_no_done", 32'(obs(0)), 32'(idle_ent(1'b1)));

      // REPEATS=2: two frames, msg_done 41 cycles after the grant.
      score_chars[1] = 16'h2468; req_score[1] = 1'b1;
      step();
      push_msg(1'b0, 16'h2468, 2, 1'b1);
      drain(1, -1);

      // REPEATS=0: frames continue until abort; out-of-range codes pass through.
      status_chars[2] = 16'hF1E0; req_status[2] = 1'b1;
      step();
      push_msg(1'b1, 16'hF1E0, 3, 1'b0);
      drain(2, -1);
      abort[2] = 1'b1;
      step();
      abort[2] = 1'b0;
      for (int i = 0; i < 3; i++) sb.push_back(idle_ent(1'b1));
      drain(2, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
